ysyx_22050039_ifu: RTL and testbench

//  Instruction fetch stage, directly upstream of the execute unit. Holds the architectural PC and

---
 rtl/ysyx_22050039_pkg.sv | 23 ++
 rtl/ysyx_22050039_ifu.sv | 171 +++++++++++++++++
 tb/tb_ysyx_22050039_ifu.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050039_pkg.sv
// Shared types and defaults for the ysyx_22050039 fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ysyx_22050039_pkg;

  localparam int          IFU_XLEN     = 64;
  localparam int          IFU_INST_LEN = 32;
  localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;

  // Fetch stage sequencing: issue request, wait for response, present instruction.
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2
  } ifu_state_t;

  // Pick the 32-bit instruction out of an aligned doubleword; hi selects bits [63:32].
  function automatic logic [IFU_INST_LEN-1:0] word_sel(input logic [IFU_XLEN-1:0] dw,
                                                       input logic                hi);
    return hi ? dw[63:32] : dw[31:0];
  endfunction

endpackage

// File: rtl/ysyx_22050039_ifu.sv
// Instruction fetch: holds the PC, fetches aligned doublewords, presents {inst, pc, fault}.
// Latency: request accepted cycle N, response N+k -> out_valid N+k+1; buffer hit back-to-back.
// Backpressure: outputs hold until out_ready; request held until mem_req_ready (redirect may retarget).
module ysyx_22050039_ifu
  import ysyx_22050039_pkg::*;
#(
  parameter int              XLEN     = IFU_XLEN,
  parameter int              INST_LEN = IFU_INST_LEN,
  parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [XLEN-1:0]     mem_req_addr,
  input  logic                mem_resp_valid,
  input  logic [XLEN-1:0]     mem_resp_data,
  input  logic                mem_resp_err,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INST_LEN-1:0] out_inst,
  output logic [XLEN-1:0]     out_pc,
  output logic                out_fault
);

  ifu_state_t          state, state_n;
  logic [XLEN-1:0]     pc, pc_n;
  logic                discard, discard_n;

  // One-line buffer: only the upper word is ever reused (sequential hit from pc[2]==0).
  logic                buf_vld, buf_vld_n;
  logic [XLEN-1:3]     buf_tag, buf_tag_n;
  logic [INST_LEN-1:0] buf_hi, buf_hi_n;

  logic [INST_LEN-1:0] inst_q, inst_n;
  logic [XLEN-1:0]     opc_q, opc_n;
  logic                fault_q, fault_n;

  logic                pc_mis;
  logic [XLEN-1:0]     pc_seq;
  logic                req_fire;
  logic                out_fire;
  logic                buf_hit;

  assign pc_mis   = (pc[1:0] != 2'b00);
  assign pc_seq   = pc + XLEN'(4);
  assign req_fire = mem_req_valid && mem_req_ready;
  assign out_fire = out_valid && out_ready;
  assign buf_hit  = buf_vld && (pc_seq[XLEN-1:3] == buf_tag);

  // Request is suppressed during reset and for a misaligned PC (which faults instead).
  assign mem_req_valid = rst && (state == REQ) && !pc_mis;
  assign mem_req_addr  = {pc[XLEN-1:3], 3'b000};

  assign out_valid = rst && (state == OUT);
  assign out_inst  = inst_q;
  assign out_pc    = opc_q;
  assign out_fault = fault_q;

  // Next-state and datapath update; redirect outranks everything else in every state.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    discard_n = discard;
    buf_vld_n = buf_vld;
    buf_tag_n = buf_tag;
    buf_hi_n  = buf_hi;
    inst_n    = inst_q;
    opc_n     = opc_q;
    fault_n   = fault_q;

    unique case (state)
      REQ: begin
        if (redirect_valid) begin
          pc_n      = redirect_pc;
          buf_vld_n = 1'b0;
          // Request already handed to memory this cycle: its response must be dropped.
          if (req_fire) begin
            discard_n = 1'b1;
            state_n   = WAIT;
          end
        end else if (pc_mis) begin
          state_n = OUT;
          inst_n  = '0;
          opc_n   = pc;
          fault_n = 1'b1;
        end else if (req_fire) begin
          state_n = WAIT;
        end
      end

      WAIT: begin
        if (redirect_valid) begin
          pc_n      = redirect_pc;
          buf_vld_n = 1'b0;
          if (mem_resp_valid) begin
            // The response arriving now belongs to the old path; drop it and refetch.
            discard_n = 1'b0;
            state_n   = REQ;
          end else begin
            discard_n = 1'b1;
          end
        end else if (mem_resp_valid) begin
          if (discard) begin
            discard_n = 1'b0;
            state_n   = REQ;
          end else begin
            buf_vld_n = !mem_resp_err;
            buf_tag_n = pc[XLEN-1:3];
            buf_hi_n  = mem_resp_data[63:32];
            inst_n    = mem_resp_err ? '0 : word_sel(mem_resp_data, pc[2]);
            opc_n     = pc;
            fault_n   = mem_resp_err;
            state_n   = OUT;
          end
        end
      end

      OUT: begin
        if (redirect_valid) begin
          // A handshake in the same cycle is ignored: the redirect target replaces pc+4.
          pc_n      = redirect_pc;
          buf_vld_n = 1'b0;
          state_n   = REQ;
        end else if (out_fire && !fault_q) begin
          pc_n = pc_seq;
          if (buf_hit) begin
            inst_n  = buf_hi;
            opc_n   = pc_seq;
            fault_n = 1'b0;
          end else begin
            state_n = REQ;
          end
        end
        // A faulted entry stays presented until a redirect arrives.
      end

      default: begin
        state_n = REQ;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= REQ;
      pc      <= RESET_PC;
      discard <= 1'b0;
      buf_vld <= 1'b0;
      buf_tag <= '0;
      buf_hi  <= '0;
      inst_q  <= '0;
      opc_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      discard <= discard_n;
      buf_vld <= buf_vld_n;
      buf_tag <= buf_tag_n;
      buf_hi  <= buf_hi_n;
      inst_q  <= inst_n;
      opc_q   <= opc_n;
      fault_q <= fault_n;
    end
  end

endmodule

// File: tb/tb_ysyx_22050039_ifu.sv
// Directed bench for the fetch stage: sequential fetch, stall, redirects, faults, reset.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_ysyx_22050039_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        mem_resp_err;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        out_fault;

  int checks   = 0;
  int failures = 0;

  ysyx_22050039_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .mem_resp_err   (mem_resp_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_fault      (out_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rpc;
    logic        ordy;
    logic        exp_req;
    logic [63:0] exp_addr;
    logic [63:0] data;
    logic        err;
    logic [31:0] exp_inst;
    logic        exp_fault;
  } redir_vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait (bounded) for a request, check its address, accept it, return a response one cycle later.
  // Starts and ends at a falling edge; on return the response has been consumed.
  task automatic serve_fetch(input string name, input logic [63:0] exp_addr,
                             input logic [63:0] data, input logic err);
    int n = 0;
    while (!mem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, " req_valid"}, {63'd0, mem_req_valid}, 64'd1);
    chk({name, " req_addr"}, mem_req_addr, exp_addr);
    mem_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk({name, " no_out_in_wait"}, {63'd0, out_valid}, 64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    mem_resp_err   = err;
    @(posedge clk);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_err   = 1'b0;
    mem_resp_data  = '0;
  endtask

  task automatic chk_out(input string name, input logic [31:0] inst,
                         input logic [63:0] pc, input logic fault);
    chk({name, " out_valid"}, {63'd0, out_valid}, 64'd1);
    chk({name, " out_inst"}, {32'd0, out_inst}, {32'd0, inst});
    chk({name, " out_pc"}, out_pc, pc);
    chk({name, " out_fault"}, {63'd0, out_fault}, {63'd0, fault});
  endtask

  redir_vec_t vecs[5];

  initial begin
    vecs[0] = '{64'h8000_0200, 1'b0, 1'b1, 64'h8000_0200, 64'h1111_1111_2222_2222, 1'b0, 32'h2222_2222, 1'b0};
    vecs[1] = '{64'h8000_020C, 1'b1, 1'b1, 64'h8000_0208, 64'h3333_3333_4444_4444, 1'b0, 32'h3333_3333, 1'b0};
    vecs[2] = '{64'h8000_0300, 1'b0, 1'b1, 64'h8000_0300, 64'h5555_5555_6666_6666, 1'b1, 32'h0000_0000, 1'b1};
    vecs[3] = '{64'h8000_0002, 1'b1, 1'b0, 64'h0,         64'h0,                   1'b0, 32'h0000_0000, 1'b1};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8,
                64'hAAAA_AAAA_BBBB_BBBB, 1'b0, 32'hAAAA_AAAA, 1'b0};

    rst = 1'b0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data = '0;
    mem_resp_err = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset req_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("reset out_inst", {32'd0, out_inst}, 64'd0);
    chk("reset out_pc", out_pc, 64'd0);
    chk("reset out_fault", {63'd0, out_fault}, 64'd0);

    // Sequential fetch with a buffer hit on the upper word
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    serve_fetch("t1", 64'h8000_0000, 64'h0010_0093_0000_0413, 1'b0);
    chk_out("t1 lo", 32'h0000_0413, 64'h8000_0000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk_out("t1 hi", 32'h0010_0093, 64'h8000_0004, 1'b0);
    chk("t1 no 2nd req", {63'd0, mem_req_valid}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("t1 out drops", {63'd0, out_valid}, 64'd0);

    // Stall: outputs hold, no request
    serve_fetch("t2", 64'h8000_0008, 64'hFFF0_0513_00A0_0593, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk_out("t2 hold", 32'h00A0_0593, 64'h8000_0008, 1'b0);
      chk("t2 hold no req", {63'd0, mem_req_valid}, 64'd0);
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk_out("t2 hi", 32'hFFF0_0513, 64'h8000_000C, 1'b0);

    // Redirect while a fetch is outstanding: stale response is dropped
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("t3 req_valid", {63'd0, mem_req_valid}, 64'd1);
    chk("t3 req_addr", mem_req_addr, 64'h8000_0010);
    mem_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0104;
    @(posedge clk);
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t3 no req while discard", {63'd0, mem_req_valid}, 64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("t3 stale not out", {63'd0, out_valid}, 64'd0);
    serve_fetch("t3", 64'h8000_0100, 64'h0040_0113_0080_0193, 1'b0);
    chk_out("t3", 32'h0040_0113, 64'h8000_0104, 1'b0);

    // Redirect table: aligned lo/hi, access fault, misaligned, top-of-memory
    foreach (vecs[k]) begin
      redirect_valid = 1'b1;
      redirect_pc = vecs[k].rpc;
      out_ready = vecs[k].ordy;
      @(posedge clk);
      @(negedge clk);
      redirect_valid = 1'b0;
      out_ready = 1'b0;
      chk($sformatf("v%0d out drops", k), {63'd0, out_valid}, 64'd0);
      if (vecs[k].exp_req) begin
        serve_fetch($sformatf("v%0d", k), vecs[k].exp_addr, vecs[k].data, vecs[k].err);
      end else begin
        logic saw_req = 1'b0;
        int   n = 0;
        while (!out_valid && n < 10) begin
          if (mem_req_valid) saw_req = 1'b1;
          @(negedge clk);
          n++;
        end
        chk($sformatf("v%0d no req", k), {63'd0, saw_req}, 64'd0);
      end
      chk_out($sformatf("v%0d", k), vecs[k].exp_inst, vecs[k].rpc, vecs[k].exp_fault);
    end

    // PC wrap from all-ones region to zero
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    serve_fetch("wrap", 64'h0, 64'h1234_5678_9ABC_DEF0, 1'b0);
    chk_out("wrap", 32'h9ABC_DEF0, 64'h0, 1'b0);

    // Faulted entry never advances on handshake
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0300;
    @(posedge clk);
    @(negedge clk);
    redirect_valid = 1'b0;
    serve_fetch("t4", 64'h8000_0300, 64'h0, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_out("t4 hold", 32'h0, 64'h8000_0300, 1'b1);
      chk("t4 no req", {63'd0, mem_req_valid}, 64'd0);
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b0;

    // Reset while waiting; response and redirect during reset are ignored
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0400;
    @(posedge clk);
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t6 req_addr", mem_req_addr, 64'h8000_0400);
    mem_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h9000_0000;
    @(posedge clk);
    @(negedge clk);
    redirect_valid = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data = 64'hCAFE_CAFE_CAFE_CAFE;
    #1;
    chk("t6 rst req_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("t6 rst out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_data = '0;
    chk("t6 rst out_inst", {32'd0, out_inst}, 64'd0);
    chk("t6 rst out_pc", out_pc, 64'd0);
    rst = 1'b1;
    #1;
    chk("t6 post out_valid", {63'd0, out_valid}, 64'd0);
    serve_fetch("t6", 64'h8000_0000, 64'h0010_0093_0000_0413, 1'b0);
    chk_out("t6", 32'h0000_0413, 64'h8000_0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
